usb_ep_rr_arb: RTL and testbench
================================

// Module: usb_ep_rr_arb
// PURPOSE
// - N-channel round-robin arbiter that grants endpoint handlers access to the
//   shared usb_fs_pe data path; successor to the fixed single-endpoint wiring.
// - Sits between the endpoint handlers (DFU control, future bulk/vendor EPs)
//   and the protocol engine.
// - Adds transaction-locked grants, a grant watchdog and SOF-based host-presence
//   gating.
// PARAMETERS
// - NUM_EPS       4      number of requesting endpoints, 1..16
// - GRANT_TIMEOUT 4096   max cycles one grant may be held before forced release
// - HOST_TIMEOUT  144000 cycles without sof_valid before host_present drops (3 ms @ 48 MHz)
// PORTS
// - clk           in   1               single clock; every flop in this block is on clk
// - reset         in   1               asynchronous, active-low; 0 = in reset
// - ep_req        in   NUM_EPS         per-EP request, level, held until done
// - ep_done       in   NUM_EPS         per-EP 1-cycle end-of-transaction pulse
// - sof_valid     in   1               1-cycle pulse per received SOF
// - ep_grant      out  NUM_EPS         one-hot grant, registered
// - grant_idx     out  $clog2(NUM_EPS) index of current/last grant (1 bit min)
// - busy          out  1               a grant is active
// - grant_timeout out  1               1-cycle pulse on watchdog-forced release
// - host_present  out  1               SOFs are arriving
// BEHAVIOUR
// - Reset values: ep_grant=0, grant_idx=0, busy=0, grant_timeout=0,
//   host_present=0, rr pointer=NUM_EPS-1, both counters 0, state IDLE.
// - FSM IDLE -> GRANT -> GAP -> IDLE.
// - IDLE: if host_present and |ep_req, pick the first requester searching
//   ptr+1, ptr+2, ... mod NUM_EPS.
//   - Grant is registered: ep_req high in cycle t gives ep_grant in cycle t+1.
//   - On grant: ptr <= granted index, grant_idx <= index, wd counter <= 0.
// - GRANT: ep_grant held stable. Release to GAP when any one of these holds:
//   - ep_done[grant_idx] is 1, or
//   - ep_req[grant_idx] drops, or
//   - wd counter == GRANT_TIMEOUT-1; this also pulses grant_timeout, or
//   - host_present falls.
//   - ep_done of any non-granted EP is ignored.
// - Priority when events coincide in one cycle: ep_done / req-drop beat the
//   timeout; no grant_timeout pulse in that case.
// - GAP: exactly one cycle with ep_grant=0, then IDLE.
//   - Minimum back-to-back grant spacing is therefore 1 idle cycle.
// - Fairness: an EP that keeps requesting waits at most NUM_EPS-1 grants.
// - Watchdog counter: saturating, width $clog2(GRANT_TIMEOUT+1). It counts only
//   in GRANT.
// - Host presence: sof counter clears on sof_valid, else increments, saturating
//   at HOST_TIMEOUT.
//   - host_present <= 1 the cycle after sof_valid.
//   - host_present <= 0 when the counter reaches HOST_TIMEOUT-1 with no SOF.
//     In that same cycle sof_valid wins.
// - NUM_EPS=1: the pointer logic degenerates. Grant, gap and watchdog behave
//   the same as for larger NUM_EPS.
// - Reset mid-grant: all outputs return to their reset values asynchronously.
//   No grant_timeout pulse is generated.
// STRUCTURE
// - Package usb_ep_arb_pkg:
//   - arb_state_t enum {ARB_IDLE, ARB_GRANT, ARB_GAP}.
//   - Width helper function ep_idx_w(n) = (n>1)?$clog2(n):1.
// - Sub-module usb_rr_pick (combinational):
//   - inputs: req vector, ptr.
//   - outputs: valid, idx.
//   - implementation: rotate, priority-encode, un-rotate.
// - The top holds the FSM, pointer, watchdog and SOF counters.
// TESTING
// - No SOF, ep_req=4'b0001 for 100 cycles -> ep_grant stays 0; one sof_valid
//   -> host_present=1 next cycle, ep_grant=4'b0001 the cycle after.
// - host_present=1, ep_req=4'b1111 held, each grant closed by ep_done 2 cycles
//   later -> grant order 0,1,2,3,0, with one zero cycle between grants.
// - Grant EP2, pulse ep_done[1] -> grant unchanged; pulse ep_done[2] -> ep_grant
//   is 0 the next cycle.
// - GRANT_TIMEOUT=8, EP0 holds req with no done -> ep_grant deasserts after 8
//   cycles; grant_timeout pulses once; next grant goes to EP1 if it requests.
// - ep_done coincident with the last watchdog cycle -> release with
//   grant_timeout=0.
// - HOST_TIMEOUT=50, stop SOFs during an EP3 grant -> host_present=0 and
//   ep_grant=0 by cycle 51. Assert reset=0 mid-grant -> all outputs 0
//   immediately.

Source files
------------

// File: rtl/usb_ep_arb_pkg.sv
// usb_ep_arb_pkg: shared types and helpers for the
// endpoint round-robin arbiter.
package usb_ep_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  function automatic int ep_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// usb_rr_pick: combinational round-robin picker; finds the
// first requester after ptr, wrapping modulo N.
module usb_rr_pick
  import usb_ep_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = ep_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  int           off;

  // Operand is always below 2*N, so one subtract wraps it.
  function automatic logic [IW-1:0] wrap(input int v);
    int w;
    w = (v >= N) ? v - N : v;
    return IW'(w);
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++)
      rot[i] = req[wrap(int'(ptr) + 1 + i)];
  end

  always_comb begin
    valid = 1'b0;
    off   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = i;
      end
    end
  end

  assign idx = wrap(int'(ptr) + 1 + off);

endmodule

// File: rtl/usb_ep_rr_arb.sv
// usb_ep_rr_arb: round-robin endpoint arbiter with locked
// grants, grant watchdog and SOF-based host presence.
module usb_ep_rr_arb
  import usb_ep_arb_pkg::*;
#(
  parameter  int NUM_EPS       = 4,
  parameter  int GRANT_TIMEOUT = 4096,
  parameter  int HOST_TIMEOUT  = 144000,
  localparam int IW = ep_idx_w(NUM_EPS),
  localparam int WW = $clog2(GRANT_TIMEOUT + 1),
  localparam int HW = $clog2(HOST_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EPS-1:0] ep_req,
  input  logic [NUM_EPS-1:0] ep_done,
  input  logic               sof_valid,
  output logic [NUM_EPS-1:0] ep_grant,
  output logic [IW-1:0]      grant_idx,
  output logic               busy,
  output logic               grant_timeout,
  output logic               host_present
);

  localparam logic [WW-1:0] WD_LAST =
    WW'(GRANT_TIMEOUT - 1);
  localparam logic [WW-1:0] WD_MAX =
    WW'(GRANT_TIMEOUT);
  localparam logic [HW-1:0] SOF_LAST =
    HW'(HOST_TIMEOUT - 1);
  localparam logic [HW-1:0] SOF_MAX =
    HW'(HOST_TIMEOUT);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [WW-1:0] wd_cnt;
  logic [HW-1:0] sof_cnt;
  logic          hp_next;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          user_end;
  logic          wd_hit;
  logic          release_now;
  logic          can_grant;

  usb_rr_pick #(.N(NUM_EPS)) u_pick (
    .req   (ep_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    hp_next = host_present;
    if (sof_valid)
      hp_next = 1'b1;
    else if (sof_cnt == SOF_LAST)
      hp_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sof_cnt      <= '0;
      host_present <= 1'b0;
    end else begin
      host_present <= hp_next;
      if (sof_valid)
        sof_cnt <= '0;
      else if (sof_cnt != SOF_MAX)
        sof_cnt <= sof_cnt + 1'b1;
    end
  end

  // Completion or request drop outranks the watchdog.
  assign user_end    = ep_done[grant_idx] |
                       ~ep_req[grant_idx];
  assign wd_hit      = (wd_cnt == WD_LAST);
  assign release_now = user_end | wd_hit | ~hp_next;
  assign can_grant   = host_present & hp_next &
                       pick_valid;
  assign busy        = (state == ARB_GRANT);

  // GAP is the single dead cycle after a grant; it may
  // arbitrate so the next grant follows immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ARB_IDLE;
      ep_grant      <= '0;
      grant_idx     <= '0;
      ptr           <= IW'(NUM_EPS - 1);
      wd_cnt        <= '0;
      grant_timeout <= 1'b0;
    end else begin
      grant_timeout <= 1'b0;
      unique case (state)
        ARB_IDLE, ARB_GAP: begin
          if (can_grant) begin
            state     <= ARB_GRANT;
            ep_grant  <= NUM_EPS'(1) << pick_idx;
            grant_idx <= pick_idx;
            ptr       <= pick_idx;
            wd_cnt    <= '0;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            state         <= ARB_GAP;
            ep_grant      <= '0;
            grant_timeout <= wd_hit & ~user_end;
          end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          ep_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_ep_rr_arb.sv
// tb_usb_ep_rr_arb: directed vectors against a per-cycle
// behavioural model of the endpoint arbiter.
module tb_usb_ep_rr_arb;

  localparam int N  = 4;
  localparam int GT = 8;
  localparam int HT = 50;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] ep_req  = '0;
  logic [N-1:0] ep_done = '0;
  logic         sof_valid = 1'b0;
  logic [N-1:0] ep_grant;
  logic [1:0]   grant_idx;
  logic         busy;
  logic         grant_timeout;
  logic         host_present;

  int tests = 0;
  int fails = 0;

  bit sof_shot = 1'b0;
  bit sof_auto = 1'b0;
  int sof_div  = 0;

  usb_ep_rr_arb #(
    .NUM_EPS       (N),
    .GRANT_TIMEOUT (GT),
    .HOST_TIMEOUT  (HT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ep_req        (ep_req),
    .ep_done       (ep_done),
    .sof_valid     (sof_valid),
    .ep_grant      (ep_grant),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .grant_timeout (grant_timeout),
    .host_present  (host_present)
  );

  always #5 clk = ~clk;

  // SOF source: one-shot on request, or every 20 cycles.
  initial forever begin
    @(posedge clk);
    #2;
    sof_valid = 1'b0;
    if (sof_shot) begin
      sof_valid = 1'b1;
      sof_shot  = 1'b0;
      sof_div   = 0;
    end else if (sof_auto) begin
      if (sof_div == 19) begin
        sof_valid = 1'b1;
        sof_div   = 0;
      end else begin
        sof_div++;
      end
    end
  end

  // Model: who owns the bus, for how long, and how long
  // since the host was last heard from.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_idx   = 0;
  int m_held  = 0;
  int m_quiet = 0;
  bit m_hp    = 1'b0;
  bit m_to    = 1'b0;

  always @(posedge clk or negedge reset) begin
    bit hp_n;
    bit d_o;
    bit r_o;
    int pick;
    if (!reset) begin
      m_owner = -1;
      m_last  = N - 1;
      m_idx   = 0;
      m_held  = 0;
      m_quiet = 0;
      m_hp    = 1'b0;
      m_to    = 1'b0;
    end else begin
      if (sof_valid)
        hp_n = 1'b1;
      else if (m_quiet == HT - 1)
        hp_n = 1'b0;
      else
        hp_n = m_hp;
      m_to = 1'b0;
      if (m_owner >= 0) begin
        d_o = ep_done[m_owner];
        r_o = ep_req[m_owner];
        if (d_o || !r_o || m_held == GT - 1 || !hp_n) begin
          m_to    = (m_held == GT - 1) && !d_o && r_o;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end else if (m_hp && hp_n) begin
        pick = -1;
        for (int k = 1; k <= N; k++)
          if (pick < 0 && ep_req[(m_last + k) % N])
            pick = (m_last + k) % N;
        if (pick >= 0) begin
          m_owner = pick;
          m_idx   = pick;
          m_last  = pick;
          m_held  = 0;
        end
      end
      if (sof_valid)
        m_quiet = 0;
      else if (m_quiet < HT)
        m_quiet++;
      m_hp = hp_n;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic         eb;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    eb = (m_owner >= 0);
    tests++;
    if (ep_grant !== eg || grant_idx !== 2'(m_idx) ||
        busy !== eb || grant_timeout !== m_to ||
        host_present !== m_hp) begin
      fails++;
      $display("FAIL model t=%0t got g=%b i=%0d b=%b to=%b hp=%b want g=%b i=%0d b=%b to=%b hp=%b",
        $time, ep_grant, grant_idx, busy, grant_timeout,
        host_present, eg, m_idx, eb, m_to, m_hp);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    logic [N-1:0] cur;
    int order [4];
    order = '{1, 2, 3, 0};

    #1 reset = 1'b0;
    cycn(3);
    chk("rst_grant", ep_grant, 0);
    chk("rst_idx", grant_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_to", grant_timeout, 0);
    chk("rst_hp", host_present, 0);
    reset = 1'b1;

    ep_req = 4'b0001;
    cycn(100);
    chk("nosof_grant", ep_grant, 0);
    chk("nosof_hp", host_present, 0);
    sof_shot = 1'b1;
    cyc();
    chk("sof_hp", host_present, 1);
    chk("sof_wait", ep_grant, 0);
    cyc();
    chk("sof_grant", ep_grant, 4'b0001);
    chk("sof_busy", busy, 1);
    sof_auto = 1'b1;

    ep_req = 4'b1111;
    cur = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_hold1", ep_grant, cur);
      cyc();
      chk("rr_hold2", ep_grant, cur);
      ep_done = cur;
      cyc();
      ep_done = '0;
      chk("rr_gap", ep_grant, 0);
      cyc();
      cur = N'(1) << order[i];
      chk("rr_grant", ep_grant, cur);
      chk("rr_idx", grant_idx, order[i]);
    end

    ep_req = 4'b0100;
    cyc();
    chk("drop_rel", ep_grant, 0);
    cyc();
    chk("ep2_grant", ep_grant, 4'b0100);
    chk("ep2_idx", grant_idx, 2);
    ep_done = 4'b0010;
    cyc();
    ep_done = '0;
    chk("other_done", ep_grant, 4'b0100);
    cyc();
    chk("other_done2", ep_grant, 4'b0100);
    ep_done = 4'b0100;
    cyc();
    ep_done = '0;
    chk("own_done", ep_grant, 0);
    chk("own_busy", busy, 0);
    ep_req = '0;
    cycn(2);
    chk("idle_grant", ep_grant, 0);

    ep_req = 4'b0011;
    cyc();
    chk("wd_grant", ep_grant, 4'b0001);
    cycn(7);
    chk("wd_hold", ep_grant, 4'b0001);
    chk("wd_early", grant_timeout, 0);
    cyc();
    chk("wd_rel", ep_grant, 0);
    chk("wd_pulse", grant_timeout, 1);
    cyc();
    chk("wd_next", ep_grant, 4'b0010);
    chk("wd_once", grant_timeout, 0);
    cycn(7);
    chk("co_hold", ep_grant, 4'b0010);
    ep_done = 4'b0010;
    cyc();
    ep_done = '0;
    ep_req  = '0;
    chk("co_rel", ep_grant, 0);
    chk("co_nopulse", grant_timeout, 0);

    sof_auto = 1'b0;
    cycn(25);
    sof_shot = 1'b1;
    cycn(44);
    ep_req = 4'b1000;
    cyc();
    chk("ht_grant", ep_grant, 4'b1000);
    chk("ht_idx", grant_idx, 3);
    cycn(5);
    chk("ht_hold", ep_grant, 4'b1000);
    chk("ht_hp1", host_present, 1);
    cyc();
    chk("ht_rel", ep_grant, 0);
    chk("ht_hp0", host_present, 0);
    chk("ht_busy", busy, 0);
    chk("ht_to", grant_timeout, 0);

    ep_req   = 4'b0100;
    sof_shot = 1'b1;
    cyc();
    chk("rg_hp", host_present, 1);
    cyc();
    chk("rg_grant", ep_grant, 4'b0100);
    chk("rg_idx", grant_idx, 2);
    #2 reset = 1'b0;
    #1;
    chk("ar_grant", ep_grant, 0);
    chk("ar_idx", grant_idx, 0);
    chk("ar_busy", busy, 0);
    chk("ar_to", grant_timeout, 0);
    chk("ar_hp", host_present, 0);
    cycn(2);
    reset  = 1'b1;
    ep_req = '0;
    cycn(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
